// File: rtl/alu_decode_stage_pkg.sv
// Shared RV32I decode definitions: ALU selects, operand selects, opcodes and
// the decoded-word bundle carried through the decode stage.
package alu_decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_sel_e;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_PC   = 2'd1,
    A_SEL_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_sel_e    alu_sel;
    a_sel_e      a_sel;
    b_sel_e      b_sel;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } dec_word_t;

  localparam int DEC_W = $bits(dec_word_t);

  // alt picks SUB over ADD and SRA over SRL; it is ignored for other funct3.
  function automatic alu_sel_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_sel_e sel;
    case (funct3)
      3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decode_stage_decode.sv
// Combinational RV32I decoder: instruction word in, ALU control word out.
// Illegal encodings keep their register indices but zero every control field.
module alu_decode
  import alu_decode_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output dec_word_t   dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [31:0] imm_shamt;
  logic        illegal;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];
  assign imm_i     = {{20{inst[31]}}, inst[31:20]};
  assign imm_s     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u     = {inst[31:12], 12'b0};
  assign imm_shamt = {27'b0, inst[24:20]};

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    illegal     = 1'b0;
    dec         = '0;
    dec.alu_sel = ALU_ADD;
    dec.a_sel   = A_SEL_RS1;
    dec.b_sel   = B_SEL_RS2;
    dec.imm     = '0;
    dec.pc      = pc;
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.rd      = inst[11:7];

    case (opcode)
      OPC_OP: begin
        if (funct7 == FUNCT7_BASE) begin
          dec.alu_sel = alu_from_funct3(funct3, 1'b0);
        end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_sel = alu_from_funct3(funct3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.b_sel = B_SEL_IMM;
        if (funct3 == 3'b001) begin
          dec.alu_sel = ALU_SLL;
          dec.imm     = imm_shamt;
          illegal     = (funct7 != FUNCT7_BASE);
        end else if (funct3 == 3'b101) begin
          dec.alu_sel = alu_from_funct3(funct3, inst[30]);
          dec.imm     = imm_shamt;
          illegal     = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
        end else begin
          dec.alu_sel = alu_from_funct3(funct3, 1'b0);
          dec.imm     = imm_i;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec.b_sel = B_SEL_IMM;
        dec.imm   = imm_i;
      end
      OPC_STORE: begin
        dec.b_sel = B_SEL_IMM;
        dec.imm   = imm_s;
      end
      OPC_BRANCH: begin
        dec.a_sel = A_SEL_PC;
        dec.b_sel = B_SEL_IMM;
        dec.imm   = imm_b;
      end
      OPC_JAL: begin
        dec.a_sel = A_SEL_PC;
        dec.b_sel = B_SEL_IMM;
        dec.imm   = imm_j;
      end
      OPC_LUI: begin
        dec.a_sel = A_SEL_ZERO;
        dec.b_sel = B_SEL_IMM;
        dec.imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec.a_sel = A_SEL_PC;
        dec.b_sel = B_SEL_IMM;
        dec.imm   = imm_u;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      dec.alu_sel = ALU_ADD;
      dec.a_sel   = A_SEL_RS1;
      dec.b_sel   = B_SEL_RS2;
      dec.imm     = '0;
    end
    dec.illegal = illegal;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage with a two-entry skid buffer between fetch and
// execute; in_ready and out_valid both come straight from flops.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_sel,
  output logic [1:0]  out_a_sel,
  output logic        out_b_sel,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  dec_word_t  dec;
  dec_word_t  main_q, main_d;
  dec_word_t  skid_q, skid_d;
  buf_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;
  logic       consume;

  alu_decode u_decode (
    .inst (in_inst),
    .pc   (in_pc),
    .dec  (dec)
  );

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (accept && consume) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so the only event is the skid word moving up.
        if (consume) begin
          main_d  = skid_q;
          state_d = ST_MAIN;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // NOTE: the data registers are reset too, because out_* must read zero
  // during reset rather than whatever was buffered before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_alu_sel = main_q.alu_sel;
  assign out_a_sel   = main_q.a_sel;
  assign out_b_sel   = main_q.b_sel;
  assign out_imm     = main_q.imm;
  assign out_pc      = main_q.pc;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed decode/handshake steps,
// async reset while full, then random traffic against a queue-based model.
module tb_alu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_sel;
  logic [1:0]  out_a_sel;
  logic        out_b_sel;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Words the stage has accepted but execute has not yet consumed.
  logic [95:0] exp_q[$];

  alu_decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_sel (out_alu_sel),
    .out_a_sel   (out_a_sel),
    .out_b_sel   (out_b_sel),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] dut_word();
    return {9'b0, out_alu_sel, out_a_sel, out_b_sel, out_imm, out_pc,
            out_rs1, out_rs2, out_rd, out_illegal};
  endfunction

  // Reference decode straight from the RV32I field rules.
  function automatic logic [95:0] ref_word(input logic [31:0] inst, input logic [31:0] pc);
    int          base[8];
    int          alu;
    int          a;
    int          b;
    logic [31:0] imm;
    logic [31:0] iimm;
    bit          ill;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    op   = inst[6:0];
    f3   = inst[14:12];
    f7   = inst[31:25];
    iimm = $signed(inst) >>> 20;
    alu  = 0; a = 0; b = 0; imm = 0; ill = 0;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) alu = base[f3];
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) alu = base[f3] + 1;
        else ill = 1;
      end
      7'h13: begin
        b = 1;
        if (f3 == 3'd1) begin
          alu = 2; imm = 32'(inst[24:20]); ill = (f7 != 7'h00);
        end else if (f3 == 3'd5) begin
          alu = (f7 == 7'h20) ? 7 : 6; imm = 32'(inst[24:20]);
          ill = !(f7 == 7'h00 || f7 == 7'h20);
        end else begin
          alu = base[f3]; imm = iimm;
        end
      end
      7'h03, 7'h67: begin b = 1; imm = iimm; end
      7'h23: begin b = 1; imm = {iimm[31:5], inst[11:7]}; end
      7'h63: begin a = 1; b = 1; imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0}; end
      7'h6F: begin a = 1; b = 1; imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}; end
      7'h37: begin a = 2; b = 1; imm = inst & 32'hFFFF_F000; end
      7'h17: begin a = 1; b = 1; imm = inst & 32'hFFFF_F000; end
      default: ill = 1;
    endcase
    if (ill) begin alu = 0; a = 0; b = 0; imm = 0; end
    return {9'b0, 4'(alu), 2'(a), 1'(b), imm, pc,
            inst[19:15], inst[24:20], inst[11:7], ill};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[11];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F, 7'h0B};
    w = $urandom();
    w[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // One clock: inputs already driven after the falling edge; compare the
  // stable outputs, let the rising edge happen, update the model.
  task automatic cycle();
    bit acc;
    bit con;
    acc = in_valid && (exp_q.size() < 2);
    con = out_ready && (exp_q.size() != 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (con) check("word", dut_word(), exp_q[0]);
    @(posedge clk);
    if (con) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ref_word(in_inst, in_pc));
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [3:0] alu, input logic [1:0] a, input logic b,
                          input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rd,
                          input logic ill);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    check({tag, ".alu_sel"}, out_alu_sel, alu);
    check({tag, ".a_sel"}, out_a_sel, a);
    check({tag, ".b_sel"}, out_b_sel, b);
    check({tag, ".imm"}, out_imm, imm);
    check({tag, ".rs1"}, out_rs1, rs1);
    check({tag, ".rd"}, out_rd, rd);
    check({tag, ".illegal"}, out_illegal, ill);
    check({tag, ".pc"}, out_pc, pc);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.word", dut_word(), 0);

    directed("add",   32'h002081B3, 32'h0000_0040, 4'd0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd3, 1'b0);
    directed("sub",   32'h402081B3, 32'h0000_0044, 4'd1, 2'd0, 1'b0, 32'h0,        5'd1, 5'd3, 1'b0);
    directed("srai",  32'h40335293, 32'h0000_0048, 4'd7, 2'd0, 1'b1, 32'h3,        5'd6, 5'd5, 1'b0);
    directed("slli1", 32'h40331293, 32'h0000_004C, 4'd0, 2'd0, 1'b0, 32'h0,        5'd6, 5'd5, 1'b1);
    directed("lui",   32'h123450B7, 32'h0000_0050, 4'd0, 2'd2, 1'b1, 32'h12345000, 5'd8, 5'd1, 1'b0);
    directed("auipc", 32'h00001097, 32'h0000_0100, 4'd0, 2'd1, 1'b1, 32'h00001000, 5'd0, 5'd1, 1'b0);
    directed("op7f",  32'h0000007F, 32'h0000_0104, 4'd0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b1);

    // Back-pressure: A and B fill the buffer, C must wait.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00110113; in_pc = 32'h0000_0200; cycle();
    in_inst = 32'h00208193; in_pc = 32'h0000_0204; cycle();
    check("bp.in_ready_full", in_ready, 0);
    check("bp.head_pc", out_pc, 32'h0000_0200);
    in_inst = 32'h00318213; in_pc = 32'h0000_0208; cycle();
    check("bp.head_stable", out_pc, 32'h0000_0200);
    out_ready = 1'b1;
    cycle();
    check("bp.second_pc", out_pc, 32'h0000_0204);
    cycle();
    in_valid = 1'b0;
    check("bp.third_pc", out_pc, 32'h0000_0208);
    cycle();
    cycle();

    // Fill to FULL, then assert reset between clock edges.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h002081B3; in_pc = 32'h0000_0300; cycle();
    in_inst = 32'h123450B7; in_pc = 32'h0000_0304; cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 0);
    check("arst.in_ready", in_ready, 1);
    check("arst.word", dut_word(), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();

    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check("drain.out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
